stride_addr_seq: RTL and testbench
==================================

// Module: stride_addr_seq
// PURPOSE
//  Access sequencer directly downstream of the DMem request arbiter (req_handle).
//  - Takes the granted lane's Base/Stride/Length and emits one data-memory address per beat:
//    Base + i*Stride, for i = 0..Length-1.
//  - Uses a valid/ready handshake toward the memory bank.
//  - At the end of a sequence, pulses the Term line of the granted lane, which releases the arbiter grant.
// PARAMETERS
//  WIDTH_ADDR    12  address / length width in bits (matches address_t)
//  WIDTH_STRIDE  12  stride width in bits (matches stride_t); zero-extended to WIDTH_ADDR
// PORTS
//  clock        in   1             system clock
//  reset        in   1             synchronous, active-high reset
//  I_GrantNo    in   2             arbiter grant number; 0 = none, 1..3 = lane
//  I_Length     in   WIDTH_ADDR    access length of the granted lane
//  I_Stride     in   WIDTH_STRIDE  stride of the granted lane
//  I_Base_Addr  in   WIDTH_ADDR    base address of the granted lane
//  I_Rdy        in   1             memory accepts the current beat
//  O_Vld        out  1             address beat valid
//  O_Addr       out  WIDTH_ADDR    current access address
//  O_Last       out  1             current beat is the final beat of the sequence
//  O_Busy       out  1             sequencer is not IDLE
//  O_LaneNo     out  2             lane owning the current sequence; 0 when IDLE
//  O_Term1      out  1             end-of-access pulse to lane 1 (arbiter I_Term1)
//  O_Term2      out  1             end-of-access pulse to lane 2
//  O_Term3      out  1             end-of-access pulse to lane 3
// BEHAVIOUR
//  FSM states and transitions:
//  - IDLE: I_GrantNo != 0 -> latch Base, Stride (zero-extended), Length and LaneNo.
//    -> RUN if Length != 0; -> TERM if Length == 0.
//  - RUN: O_Vld = 1, O_Addr = R_Addr.
//    - Beat fires on O_Vld & I_Rdy.
//    - On fire: R_Addr <= R_Addr + R_Stride, R_Cnt <= R_Cnt + 1.
//    - If the fired beat had O_Last = 1 -> TERM.
//  - TERM: exactly one cycle; O_TermN = 1 for N == R_LaneNo -> IDLE.
//  Timing and latency:
//  - Latency: grant seen in cycle G; first O_Vld in cycle G+1.
//  - Term is asserted 1 cycle after the last beat fires.
//  - Throughput: 1 beat/cycle while I_Rdy = 1.
//  Handshake rules:
//  - O_Addr and O_Last are held stable while O_Vld & ~I_Rdy.
//  - O_Vld never drops in RUN until the last beat fires.
//  - I_Base_Addr, I_Stride and I_Length are sampled only in IDLE; later changes are ignored.
//  Arithmetic and width rules:
//  - Address arithmetic is modulo 2^WIDTH_ADDR; wrap-around is silent, with no error.
//  - O_Last = (R_Cnt == R_Length - 1); R_Cnt is WIDTH_ADDR bits.
//  - Length = all ones is legal and gives 2^WIDTH_ADDR - 1 beats.
//  - Stride = 0 is legal and repeats Base Length times.
//  Re-arm after Term:
//  - The arbiter clears its grant 1 cycle after Term, so IDLE sees I_GrantNo = 0 before re-arming.
//  - The sequencer never re-triggers on a stale grant.
//  - A back-to-back request from the same lane starts in cycle TERM+2 at the earliest.
//  Grant changes while busy:
//  - Changes on I_GrantNo while RUN/TERM are ignored.
//  - The latched LaneNo owns the sequence until Term.
//  Reset:
//  - Values after reset: state = IDLE, O_Vld = 0, O_Addr = 0, O_Last = 0, O_Busy = 0,
//    O_LaneNo = 0, O_Term1..3 = 0, R_Cnt = 0.
//  - Reset mid-RUN aborts on the next edge and no Term is issued.
//  - At most one of O_Term1..3 is high in any cycle.
// TESTING
//  1. Normal sequence: GrantNo=1, Base=0x010, Stride=4, Len=3, Rdy=1
//     -> addrs 0x010, 0x014, 0x018 on 3 consecutive cycles; O_Last on 0x018;
//     O_Term1 pulses 1 cycle later.
//  2. Backpressure: GrantNo=2, Base=0x100, Stride=1, Len=4, Rdy toggled 1,0,0,1,1,0,1
//     -> 4 beats 0x100..0x103; address held during stalls; single O_Term2 pulse.
//  3. Zero length: GrantNo=3, Len=0 -> O_Vld is never asserted; O_Term3 pulses in cycle G+1.
//  4. Wrap-around: Base=0xFFE, Stride=3, Len=3 (WIDTH_ADDR=12) -> addrs 0xFFE, 0x001, 0x004.
//  5. Reset mid-run: reset at beat 2 of Len=8 -> next cycle O_Vld=0, O_Busy=0; no O_TermN pulse.
//  6. Re-arm: lane 1 Len=2 is followed by a held grant to lane 1 (Req1 kept high)
//     -> the second sequence starts only after the grant drops and returns;
//     no duplicate start; Terms are exactly 2.

Source files
------------

// File: rtl/stride_addr_seq.sv
// Strided address sequencer: turns a granted lane's Base/Stride/Length into
// one memory address per beat (Base + i*Stride) over a valid/ready handshake,
// then pulses the owning lane's Term line to release the arbiter grant.
module stride_addr_seq #(
    parameter int unsigned WIDTH_ADDR   = 12,
    parameter int unsigned WIDTH_STRIDE = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              I_GrantNo,
    input  logic [WIDTH_ADDR-1:0]   I_Length,
    input  logic [WIDTH_STRIDE-1:0] I_Stride,
    input  logic [WIDTH_ADDR-1:0]   I_Base_Addr,
    input  logic                    I_Rdy,
    output logic                    O_Vld,
    output logic [WIDTH_ADDR-1:0]   O_Addr,
    output logic                    O_Last,
    output logic                    O_Busy,
    output logic [1:0]              O_LaneNo,
    output logic                    O_Term1,
    output logic                    O_Term2,
    output logic                    O_Term3
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TERM = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH_ADDR-1:0] r_addr;
    logic [WIDTH_ADDR-1:0] r_stride;
    logic [WIDTH_ADDR-1:0] r_length;
    logic [WIDTH_ADDR-1:0] r_cnt;
    logic [1:0]            r_lane;
    logic                  r_armed;

    logic start_c;
    logic fire_c;
    logic last_c;

    // A grant is accepted only once IDLE has seen the grant line low since the last Term.
    assign start_c = (state == S_IDLE) && r_armed && (I_GrantNo != 2'd0);
    assign fire_c  = (state == S_RUN) && I_Rdy;
    assign last_c  = (r_cnt == (r_length - WIDTH_ADDR'(1)));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_c) begin
                    state_nxt = (I_Length == '0) ? S_TERM : S_RUN;
                end
            end
            S_RUN: begin
                if (fire_c && last_c) begin
                    state_nxt = S_TERM;
                end
            end
            S_TERM:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sequence context: latched at start, advanced on every fired beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_length <= '0;
            r_cnt    <= '0;
            r_lane   <= 2'd0;
        end else if (start_c) begin
            r_addr   <= I_Base_Addr;
            r_stride <= WIDTH_ADDR'(I_Stride);
            r_length <= I_Length;
            r_cnt    <= '0;
            r_lane   <= I_GrantNo;
        end else if (fire_c) begin
            r_addr   <= r_addr + r_stride;
            r_cnt    <= r_cnt + WIDTH_ADDR'(1);
        end
    end

    // Re-arm guard: disarm on Term, re-arm once the stale grant has dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_armed <= 1'b1;
        end else if (state == S_TERM) begin
            r_armed <= 1'b0;
        end else if ((state == S_IDLE) && (I_GrantNo == 2'd0)) begin
            r_armed <= 1'b1;
        end
    end

    // Output decode from registered state and context only.
    always_comb begin
        O_Vld    = 1'b0;
        O_Addr   = r_addr;
        O_Last   = 1'b0;
        O_Busy   = 1'b0;
        O_LaneNo = 2'd0;
        O_Term1  = 1'b0;
        O_Term2  = 1'b0;
        O_Term3  = 1'b0;
        case (state)
            S_RUN: begin
                O_Vld    = 1'b1;
                O_Last   = last_c;
                O_Busy   = 1'b1;
                O_LaneNo = r_lane;
            end
            S_TERM: begin
                O_Busy   = 1'b1;
                O_LaneNo = r_lane;
                O_Term1  = (r_lane == 2'd1);
                O_Term2  = (r_lane == 2'd2);
                O_Term3  = (r_lane == 2'd3);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stride_addr_seq.sv
// Scoreboard bench for stride_addr_seq: directed sequences push hand-computed
// beats and Term lanes into queues; a negedge monitor pops and compares.
module tb_stride_addr_seq;

    logic        clock;
    logic        reset;
    logic [1:0]  I_GrantNo;
    logic [11:0] I_Length;
    logic [11:0] I_Stride;
    logic [11:0] I_Base_Addr;
    logic        I_Rdy;
    logic        O_Vld;
    logic [11:0] O_Addr;
    logic        O_Last;
    logic        O_Busy;
    logic [1:0]  O_LaneNo;
    logic        O_Term1;
    logic        O_Term2;
    logic        O_Term3;

    typedef struct packed {
        logic [11:0] addr;
        logic        last;
        logic [1:0]  lane;
    } beat_t;

    beat_t      beat_q[$];
    logic [1:0] term_q[$];

    int vectors;
    int miscompares;
    int term_seen;

    logic        prev_stall;
    logic [11:0] prev_addr;
    logic        prev_last;

    stride_addr_seq #(.WIDTH_ADDR(12), .WIDTH_STRIDE(12)) dut (
        .clock      (clock),
        .reset      (reset),
        .I_GrantNo  (I_GrantNo),
        .I_Length   (I_Length),
        .I_Stride   (I_Stride),
        .I_Base_Addr(I_Base_Addr),
        .I_Rdy      (I_Rdy),
        .O_Vld      (O_Vld),
        .O_Addr     (O_Addr),
        .O_Last     (O_Last),
        .O_Busy     (O_Busy),
        .O_LaneNo   (O_LaneNo),
        .O_Term1    (O_Term1),
        .O_Term2    (O_Term2),
        .O_Term3    (O_Term3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void push_beat(input logic [11:0] a, input logic l, input logic [1:0] ln);
        beat_t b;
        b.addr = a;
        b.last = l;
        b.lane = ln;
        beat_q.push_back(b);
    endfunction

    // Monitor: compares fired beats, Term pulses and stall stability.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_vld_held", 32'(O_Vld), 32'd1);
                check("stall_addr_held", 32'(O_Addr), 32'(prev_addr));
                check("stall_last_held", 32'(O_Last), 32'(prev_last));
            end
            if (O_Vld && I_Rdy) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", 32'(O_Addr), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = beat_q.pop_front();
                    check("beat_addr", 32'(O_Addr), 32'(e.addr));
                    check("beat_last", 32'(O_Last), 32'(e.last));
                    check("beat_lane", 32'(O_LaneNo), 32'(e.lane));
                end
            end
            if (O_Term1 || O_Term2 || O_Term3) begin
                logic [1:0] got;
                term_seen++;
                got = O_Term1 ? 2'd1 : (O_Term2 ? 2'd2 : 2'd3);
                check("term_onehot", 32'({O_Term1, O_Term2, O_Term3}) & 32'(32'({O_Term1, O_Term2, O_Term3}) - 32'd1), 32'd0);
                if (term_q.size() == 0) begin
                    check("unexpected_term", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    check("term_lane", 32'(got), 32'(term_q.pop_front()));
                end
            end
            prev_stall <= O_Vld && !I_Rdy;
            prev_addr  <= O_Addr;
            prev_last  <= O_Last;
        end
    end

    task automatic issue(input logic [1:0] lane, input logic [11:0] base,
                         input logic [11:0] stride, input logic [11:0] len);
        @(posedge clock); #1;
        I_GrantNo   = lane;
        I_Base_Addr = base;
        I_Stride    = stride;
        I_Length    = len;
    endtask

    // Arbiter model: wait for Term, then drop the grant the next cycle.
    task automatic await_term(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (O_Term1 || O_Term2 || O_Term3) seen = 1'b1;
        end
        if (!seen) check("term_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        I_GrantNo = 2'd0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rdy_pat[7];
        vectors     = 0;
        miscompares = 0;
        term_seen   = 0;
        reset       = 1'b1;
        I_GrantNo   = 2'd0;
        I_Length    = 12'd0;
        I_Stride    = 12'd0;
        I_Base_Addr = 12'd0;
        I_Rdy       = 1'b1;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_vld", 32'(O_Vld), 32'd0);
        check("rst_addr", 32'(O_Addr), 32'd0);
        check("rst_last", 32'(O_Last), 32'd0);
        check("rst_busy", 32'(O_Busy), 32'd0);
        check("rst_lane", 32'(O_LaneNo), 32'd0);
        check("rst_terms", 32'({O_Term1, O_Term2, O_Term3}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle_cycles(2);

        // 1. Normal sequence, with latency checks
        push_beat(12'h010, 1'b0, 2'd1);
        push_beat(12'h014, 1'b0, 2'd1);
        push_beat(12'h018, 1'b1, 2'd1);
        term_q.push_back(2'd1);
        issue(2'd1, 12'h010, 12'd4, 12'd3);
        @(negedge clock);
        check("t1_vld_in_G", 32'(O_Vld), 32'd0);
        @(negedge clock);
        check("t1_vld_G1", 32'(O_Vld), 32'd1);
        check("t1_busy_G1", 32'(O_Busy), 32'd1);
        await_term(20);
        idle_cycles(2);

        // 2. Backpressure
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        push_beat(12'h100, 1'b0, 2'd2);
        push_beat(12'h101, 1'b0, 2'd2);
        push_beat(12'h102, 1'b0, 2'd2);
        push_beat(12'h103, 1'b1, 2'd2);
        term_q.push_back(2'd2);
        issue(2'd2, 12'h100, 12'd1, 12'd4);
        for (int k = 0; k < 7; k++) begin
            @(posedge clock); #1;
            I_Rdy = rdy_pat[k];
        end
        await_term(20);
        I_Rdy = 1'b1;
        idle_cycles(2);

        // 3. Zero length: Term in G+1, no valid beat
        term_q.push_back(2'd3);
        issue(2'd3, 12'h300, 12'd5, 12'd0);
        @(negedge clock);
        check("t3_vld_G", 32'(O_Vld), 32'd0);
        @(negedge clock);
        check("t3_vld_G1", 32'(O_Vld), 32'd0);
        check("t3_term3_G1", 32'(O_Term3), 32'd1);
        @(posedge clock); #1;
        I_GrantNo = 2'd0;
        idle_cycles(2);

        // 4. Wrap-around; inputs and grant change mid-run are ignored
        push_beat(12'hFFE, 1'b0, 2'd2);
        push_beat(12'h001, 1'b0, 2'd2);
        push_beat(12'h004, 1'b1, 2'd2);
        term_q.push_back(2'd2);
        issue(2'd2, 12'hFFE, 12'd3, 12'd3);
        @(posedge clock); #1;
        I_GrantNo   = 2'd3;
        I_Base_Addr = 12'h555;
        I_Stride    = 12'd9;
        I_Length    = 12'd7;
        await_term(20);
        idle_cycles(2);

        // 7. Zero stride repeats base
        push_beat(12'h123, 1'b0, 2'd3);
        push_beat(12'h123, 1'b1, 2'd3);
        term_q.push_back(2'd3);
        issue(2'd3, 12'h123, 12'd0, 12'd2);
        await_term(20);
        idle_cycles(2);

        // 5. Reset mid-run at beat 2 of 8: no Term afterwards
        push_beat(12'h200, 1'b0, 2'd1);
        push_beat(12'h202, 1'b0, 2'd1);
        issue(2'd1, 12'h200, 12'd2, 12'd8);
        idle_cycles(2);
        @(posedge clock); #1;
        reset     = 1'b1;
        I_GrantNo = 2'd0;
        @(negedge clock);
        @(negedge clock);
        check("t5_vld_after_rst", 32'(O_Vld), 32'd0);
        check("t5_busy_after_rst", 32'(O_Busy), 32'd0);
        check("t5_terms_after_rst", 32'({O_Term1, O_Term2, O_Term3}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle_cycles(4);

        // 6. Re-arm: grant held after Term must not restart
        push_beat(12'h040, 1'b0, 2'd1);
        push_beat(12'h048, 1'b1, 2'd1);
        term_q.push_back(2'd1);
        issue(2'd1, 12'h040, 12'd8, 12'd2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (O_Term1) break;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t6_no_restart", 32'(O_Busy), 32'd0);
        end
        @(posedge clock); #1;
        I_GrantNo = 2'd0;
        push_beat(12'h040, 1'b0, 2'd1);
        push_beat(12'h048, 1'b1, 2'd1);
        term_q.push_back(2'd1);
        issue(2'd1, 12'h040, 12'd8, 12'd2);
        await_term(20);
        idle_cycles(3);

        // Final accounting
        check("beat_q_empty", 32'(beat_q.size()), 32'd0);
        check("term_q_empty", 32'(term_q.size()), 32'd0);
        check("term_total", 32'(term_seen), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
